// File: rtl/shot_if.sv
// Player-side bundle for the shot controller: frame strobe, fire/aim inputs,
// target cell, and the shot position/result outputs.
interface shot_if;
    logic       tick;
    logic       fire;
    logic [4:0] x_pos;
    logic [4:0] run;
    logic [4:0] rise;
    logic       dir;
    logic [4:0] target_x;
    logic [4:0] target_y;
    logic [4:0] shot_x;
    logic [4:0] shot_y;
    logic       shot_active;
    logic       aim_lock;
    logic       hit;
    logic       miss;
    logic [7:0] shots_fired;

    modport master (
        output tick, fire, x_pos, run, rise, dir, target_x, target_y,
        input  shot_x, shot_y, shot_active, aim_lock, hit, miss, shots_fired
    );

    modport slave (
        input  tick, fire, x_pos, run, rise, dir, target_x, target_y,
        output shot_x, shot_y, shot_active, aim_lock, hit, miss, shots_fired
    );
endinterface

// File: rtl/shot_ctrl.sv
// Launches one shot from the latched aim, steps it on each frame tick,
// reports hit/miss, then holds off new fires for a tick-counted cooldown.
module shot_ctrl #(
    parameter int unsigned Y_MAX    = 23,
    parameter int unsigned COOLDOWN = 8
) (
    input  logic   clk,
    input  logic   reset,
    shot_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, FLY, COOL} state_e;

    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic signed [6:0] Y_LIMIT = 7'(Y_MAX);

    state_e          state_q, state_d;
    logic [4:0]      shot_x_q, shot_x_d;
    logic [4:0]      shot_y_q, shot_y_d;
    logic [4:0]      run_q, run_d;
    logic [4:0]      rise_q, rise_d;
    logic            dir_q, dir_d;
    logic [CW-1:0]   cool_cnt_q, cool_cnt_d;
    logic [7:0]      shots_fired_q, shots_fired_d;
    logic            hit_q, hit_d;
    logic            miss_q, miss_d;

    logic signed [6:0] nx;
    logic signed [6:0] ny;
    logic              out_of_bounds;

    // Candidate next position; 7 bits so a step past either wall stays visible.
    always_comb begin
        nx = dir_q ? ({2'b00, shot_x_q} + {2'b00, run_q})
                   : ({2'b00, shot_x_q} - {2'b00, run_q});
        ny = {2'b00, shot_y_q} + {2'b00, rise_q};
        out_of_bounds = (nx < 7'sd0) || (nx > 7'sd31) || (ny > Y_LIMIT);
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        shot_x_d      = shot_x_q;
        shot_y_d      = shot_y_q;
        run_d         = run_q;
        rise_d        = rise_q;
        dir_d         = dir_q;
        cool_cnt_d    = cool_cnt_q;
        shots_fired_d = shots_fired_q;
        hit_d         = 1'b0;
        miss_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.fire) begin
                    state_d       = LOAD;
                    shots_fired_d = shots_fired_q + 8'd1;
                end
            end
            LOAD: begin
                run_d    = bus.run;
                rise_d   = bus.rise;
                dir_d    = bus.dir;
                shot_x_d = bus.x_pos;
                shot_y_d = 5'd0;
                // A zero aim would never leave the field, so end it at once.
                if (bus.run == 5'd0 && bus.rise == 5'd0) begin
                    state_d    = COOL;
                    miss_d     = 1'b1;
                    cool_cnt_d = CW'(COOLDOWN);
                end else begin
                    state_d = FLY;
                end
            end
            FLY: begin
                if (bus.tick) begin
                    if (out_of_bounds) begin
                        state_d    = COOL;
                        miss_d     = 1'b1;
                        cool_cnt_d = CW'(COOLDOWN);
                    end else begin
                        shot_x_d = nx[4:0];
                        shot_y_d = ny[4:0];
                        if (nx[4:0] == bus.target_x && ny[4:0] == bus.target_y) begin
                            state_d    = COOL;
                            hit_d      = 1'b1;
                            cool_cnt_d = CW'(COOLDOWN);
                        end
                    end
                end
            end
            COOL: begin
                if (COOLDOWN == 0) begin
                    state_d = IDLE;
                end else if (bus.tick) begin
                    cool_cnt_d = cool_cnt_q - CW'(1);
                    if (cool_cnt_q == CW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            shot_x_q      <= 5'd0;
            shot_y_q      <= 5'd0;
            run_q         <= 5'd0;
            rise_q        <= 5'd0;
            dir_q         <= 1'b0;
            cool_cnt_q    <= '0;
            shots_fired_q <= 8'd0;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shot_x_q      <= shot_x_d;
            shot_y_q      <= shot_y_d;
            run_q         <= run_d;
            rise_q        <= rise_d;
            dir_q         <= dir_d;
            cool_cnt_q    <= cool_cnt_d;
            shots_fired_q <= shots_fired_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
        end
    end

    assign bus.shot_x      = shot_x_q;
    assign bus.shot_y      = shot_y_q;
    assign bus.shot_active = (state_q == LOAD) || (state_q == FLY);
    assign bus.aim_lock    = (state_q != IDLE);
    assign bus.hit         = hit_q;
    assign bus.miss        = miss_q;
    assign bus.shots_fired = shots_fired_q;
endmodule

// File: tb/tb_shot_ctrl.sv
// Directed bench for shot_ctrl: each task drives one scenario and checks
// outputs against hand-computed values one time unit after the clock edge.
module tb_shot_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    shot_if bus ();

    shot_ctrl #(.Y_MAX(23), .COOLDOWN(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    task automatic drain_cooldown();
        for (int i = 0; i < 8; i++) pulse_tick();
    endtask

    task automatic aim(input logic [4:0] x, input logic d, input logic [4:0] r,
                       input logic [4:0] ri, input logic [4:0] tx, input logic [4:0] ty);
        bus.x_pos = x; bus.dir = d; bus.run = r; bus.rise = ri;
        bus.target_x = tx; bus.target_y = ty;
    endtask

    task automatic test_reset();
        logic [22:0] got;
        step(); step();
        got = {bus.shot_x, bus.shot_y, bus.shot_active, bus.aim_lock, bus.hit, bus.miss, bus.shots_fired};
        n_total++;
        if (got !== 23'd0) $display("FAIL reset_outputs got %h want 0", got); else n_pass++;
        reset = 1'b1;
        step();
        pulse_tick();
        n_total++;
        if ({bus.aim_lock, bus.shot_active} !== 2'b00)
            $display("FAIL idle_tick_ignored got %b want 00", {bus.aim_lock, bus.shot_active});
        else n_pass++;
    endtask

    task automatic test_diag_hit();
        aim(5'd10, 1'b1, 5'd1, 5'd1, 5'd13, 5'd3);
        bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
        n_total++;
        if ({bus.aim_lock, bus.shot_active, bus.shots_fired} !== {2'b11, 8'd1})
            $display("FAIL diag_fire got lock=%b act=%b sf=%0d want 1 1 1", bus.aim_lock, bus.shot_active, bus.shots_fired);
        else n_pass++;
        step();
        // Upstream aim changes after LOAD must not steer the shot.
        aim(5'd0, 1'b0, 5'd7, 5'd7, 5'd13, 5'd3);
        n_total++;
        if ({bus.shot_x, bus.shot_y} !== {5'd10, 5'd0})
            $display("FAIL diag_launch got (%0d,%0d) want (10,0)", bus.shot_x, bus.shot_y);
        else n_pass++;
        pulse_tick();
        n_total++;
        if ({bus.shot_x, bus.shot_y, bus.hit, bus.miss} !== {5'd11, 5'd1, 2'b00})
            $display("FAIL diag_step1 got (%0d,%0d) h=%b m=%b want (11,1) 0 0", bus.shot_x, bus.shot_y, bus.hit, bus.miss);
        else n_pass++;
        pulse_tick();
        n_total++;
        if ({bus.shot_x, bus.shot_y, bus.hit} !== {5'd12, 5'd2, 1'b0})
            $display("FAIL diag_step2 got (%0d,%0d) h=%b want (12,2) 0", bus.shot_x, bus.shot_y, bus.hit);
        else n_pass++;
        pulse_tick();
        n_total++;
        if ({bus.shot_x, bus.shot_y, bus.hit, bus.miss, bus.shot_active, bus.aim_lock} !== {5'd13, 5'd3, 4'b1001})
            $display("FAIL diag_hit got (%0d,%0d) h=%b m=%b act=%b lock=%b want (13,3) 1 0 0 1",
                     bus.shot_x, bus.shot_y, bus.hit, bus.miss, bus.shot_active, bus.aim_lock);
        else n_pass++;
        step();
        n_total++;
        if ({bus.hit, bus.miss, bus.shot_x, bus.shot_y} !== {2'b00, 5'd13, 5'd3})
            $display("FAIL diag_hit_pulse_end got h=%b m=%b (%0d,%0d) want 0 0 (13,3)", bus.hit, bus.miss, bus.shot_x, bus.shot_y);
        else n_pass++;
        for (int i = 0; i < 7; i++) pulse_tick();
        n_total++;
        if (bus.aim_lock !== 1'b1) $display("FAIL diag_cool7 got lock=%b want 1", bus.aim_lock); else n_pass++;
        pulse_tick();
        n_total++;
        if (bus.aim_lock !== 1'b0) $display("FAIL diag_cool8 got lock=%b want 0", bus.aim_lock); else n_pass++;
    endtask

    task automatic test_left_miss();
        aim(5'd3, 1'b0, 5'd2, 5'd1, 5'd0, 5'd9);
        bus.fire = 1'b1;
        bus.tick = 1'b1;
        step();
        bus.fire = 1'b0;
        bus.tick = 1'b0;
        n_total++;
        if ({bus.shot_active, bus.shots_fired} !== {1'b1, 8'd2})
            $display("FAIL left_fire_with_tick got act=%b sf=%0d want 1 2", bus.shot_active, bus.shots_fired);
        else n_pass++;
        step();
        pulse_tick();
        n_total++;
        if ({bus.shot_x, bus.shot_y, bus.miss} !== {5'd1, 5'd1, 1'b0})
            $display("FAIL left_step1 got (%0d,%0d) m=%b want (1,1) 0", bus.shot_x, bus.shot_y, bus.miss);
        else n_pass++;
        pulse_tick();
        n_total++;
        if ({bus.shot_x, bus.shot_y, bus.hit, bus.miss, bus.shot_active, bus.aim_lock} !== {5'd1, 5'd1, 4'b0101})
            $display("FAIL left_wall_miss got (%0d,%0d) h=%b m=%b act=%b lock=%b want (1,1) 0 1 0 1",
                     bus.shot_x, bus.shot_y, bus.hit, bus.miss, bus.shot_active, bus.aim_lock);
        else n_pass++;
        drain_cooldown();
    endtask

    task automatic test_top_miss();
        aim(5'd5, 1'b1, 5'd0, 5'd1, 5'd20, 5'd20);
        bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
        step();
        for (int i = 0; i < 23; i++) pulse_tick();
        n_total++;
        if ({bus.shot_x, bus.shot_y, bus.miss, bus.shot_active} !== {5'd5, 5'd23, 2'b01})
            $display("FAIL top_tick23 got (%0d,%0d) m=%b act=%b want (5,23) 0 1", bus.shot_x, bus.shot_y, bus.miss, bus.shot_active);
        else n_pass++;
        pulse_tick();
        n_total++;
        if ({bus.shot_x, bus.shot_y, bus.miss, bus.hit, bus.shots_fired} !== {5'd5, 5'd23, 2'b10, 8'd3})
            $display("FAIL top_tick24_miss got (%0d,%0d) m=%b h=%b sf=%0d want (5,23) 1 0 3",
                     bus.shot_x, bus.shot_y, bus.miss, bus.hit, bus.shots_fired);
        else n_pass++;
        drain_cooldown();
    endtask

    task automatic test_ignored_fires();
        aim(5'd30, 1'b1, 5'd1, 5'd0, 5'd0, 5'd20);
        bus.fire = 1'b1;
        step();
        step();
        pulse_tick();
        n_total++;
        if ({bus.shot_x, bus.shot_y, bus.shots_fired} !== {5'd31, 5'd0, 8'd4})
            $display("FAIL ign_edge_col got (%0d,%0d) sf=%0d want (31,0) 4", bus.shot_x, bus.shot_y, bus.shots_fired);
        else n_pass++;
        pulse_tick();
        n_total++;
        if ({bus.miss, bus.shot_x, bus.shots_fired} !== {1'b1, 5'd31, 8'd4})
            $display("FAIL ign_right_miss got m=%b x=%0d sf=%0d want 1 31 4", bus.miss, bus.shot_x, bus.shots_fired);
        else n_pass++;
        for (int i = 0; i < 7; i++) pulse_tick();
        n_total++;
        if ({bus.aim_lock, bus.shots_fired} !== {1'b1, 8'd4})
            $display("FAIL ign_cool7 got lock=%b sf=%0d want 1 4", bus.aim_lock, bus.shots_fired);
        else n_pass++;
        pulse_tick();
        n_total++;
        if ({bus.aim_lock, bus.shots_fired} !== {1'b0, 8'd4})
            $display("FAIL ign_idle_reached got lock=%b sf=%0d want 0 4", bus.aim_lock, bus.shots_fired);
        else n_pass++;
        step();
        bus.fire = 1'b0;
        n_total++;
        if ({bus.shot_active, bus.shots_fired} !== {1'b1, 8'd5})
            $display("FAIL ign_refire got act=%b sf=%0d want 1 5", bus.shot_active, bus.shots_fired);
        else n_pass++;
        step();
        pulse_tick();
        pulse_tick();
        drain_cooldown();
    endtask

    task automatic test_degenerate();
        aim(5'd7, 1'b1, 5'd0, 5'd0, 5'd7, 5'd0);
        bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
        step();
        n_total++;
        if ({bus.miss, bus.hit, bus.shot_active, bus.aim_lock, bus.shot_x, bus.shot_y, bus.shots_fired} !== {4'b1001, 5'd7, 5'd0, 8'd6})
            $display("FAIL degen_miss got m=%b h=%b act=%b lock=%b (%0d,%0d) sf=%0d want 1 0 0 1 (7,0) 6",
                     bus.miss, bus.hit, bus.shot_active, bus.aim_lock, bus.shot_x, bus.shot_y, bus.shots_fired);
        else n_pass++;
        step();
        n_total++;
        if (bus.miss !== 1'b0) $display("FAIL degen_pulse_end got m=%b want 0", bus.miss); else n_pass++;
        drain_cooldown();
        n_total++;
        if (bus.aim_lock !== 1'b0) $display("FAIL degen_idle got lock=%b want 0", bus.aim_lock); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        logic [22:0] got;
        logic        saw_result;
        aim(5'd10, 1'b1, 5'd1, 5'd1, 5'd13, 5'd3);
        bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
        step();
        pulse_tick();
        pulse_tick();
        #2;
        reset = 1'b0;
        #1;
        got = {bus.shot_x, bus.shot_y, bus.shot_active, bus.aim_lock, bus.hit, bus.miss, bus.shots_fired};
        n_total++;
        if (got !== 23'd0) $display("FAIL midflight_reset got %h want 0", got); else n_pass++;
        saw_result = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            saw_result = saw_result | bus.hit | bus.miss;
        end
        n_total++;
        if (saw_result !== 1'b0) $display("FAIL midflight_no_result got %b want 0", saw_result); else n_pass++;
        reset = 1'b1;
        step();
        bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
        n_total++;
        if ({bus.aim_lock, bus.shots_fired} !== {1'b1, 8'd1})
            $display("FAIL post_reset_fire got lock=%b sf=%0d want 1 1", bus.aim_lock, bus.shots_fired);
        else n_pass++;
        step();
        for (int i = 0; i < 3; i++) pulse_tick();
        n_total++;
        if ({bus.shot_x, bus.shot_y, bus.hit} !== {5'd13, 5'd3, 1'b1})
            $display("FAIL post_reset_hit got (%0d,%0d) h=%b want (13,3) 1", bus.shot_x, bus.shot_y, bus.hit);
        else n_pass++;
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.fire = 1'b0;
        aim(5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_diag_hit();
        test_left_miss();
        test_top_miss();
        test_ignored_fires();
        test_degenerate();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/shot_ctrl.md
Name: shot_ctrl

Overview:
- Sequences one projectile launch from the player's current position and aim (x position, run, rise, direction) and steps it across the 32-column playfield on each frame tick.
- Detects a hit against a target cell, or a miss when the shot leaves the field.
- Enforces a cooldown between shots.
- Drives aim_lock so the position/aim logic is held frozen while a shot is in progress.

Parameters:
- Y_MAX, 23: highest valid row; a step whose row would exceed this ends the shot as a miss.
- COOLDOWN, 8: number of tick pulses after a shot ends before a new fire is accepted; 0 means no cooldown.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- tick  input  1  frame-step strobe, one clk wide
- fire  input  1  launch request; level sampled each clk
- x_pos  input  5  launcher column
- run  input  5  horizontal step magnitude per tick
- rise  input  5  vertical step per tick
- dir  input  1  0 = column decreases, 1 = column increases
- target_x  input  5  target column
- target_y  input  5  target row
- shot_x  output  5  current shot column
- shot_y  output  5  current shot row
- shot_active  output  1  high in LOAD and FLY
- aim_lock  output  1  high whenever state is not IDLE
- hit  output  1  one-clk pulse when the shot lands on the target
- miss  output  1  one-clk pulse when the shot ends without a hit
- shots_fired  output  8  count of accepted fires, wraps 255 -> 0

Behaviour:
- Reset (async, reset=0): state=IDLE; shot_x=0, shot_y=0, all 1-bit outputs 0, shots_fired=0, cooldown counter=0, latched run/rise/dir=0.
- States: IDLE, LOAD, FLY, COOL.
- IDLE:
  - fire=1 -> LOAD on the next edge; shots_fired increments on that edge.
  - tick is ignored in IDLE.
  - fire and tick in the same cycle: fire is accepted.
- LOAD (exactly 1 cycle):
  - Latch run, rise and dir.
  - shot_x <= x_pos, shot_y <= 0.
  - Go to FLY.
  - If latched run=0 and rise=0: go to COOL instead and pulse miss (guards against a shot that never moves).
- FLY: on each tick, compute in 7-bit signed space:
  - nx = shot_x - run (dir=0) or shot_x + run (dir=1)
  - ny = shot_y + rise
  - Out-of-bounds means nx<0, nx>31 or ny>Y_MAX. When out of bounds: shot_x/shot_y keep their last in-bounds values, miss pulses, state goes to COOL.
  - Otherwise shot_x<=nx and shot_y<=ny. If (nx,ny) equals (target_x,target_y): hit pulses and state goes to COOL.
  - The hit check applies only to the newly stepped position, never to the launch cell. The target is sampled live each tick.
  - No tick: hold everything.
- Result latency: hit and miss are registered and assert in the cycle after the deciding tick edge. They are mutually exclusive and never assert outside the FLY->COOL or LOAD->COOL transition.
- COOL:
  - On entry, load the counter with COOLDOWN; decrement on each tick.
  - Return to IDLE on the tick that brings the counter to 0.
  - COOLDOWN=0: COOL lasts exactly 1 clk, then IDLE.
  - fire in COOL, LOAD or FLY is ignored and does not count.
  - shot_x/shot_y hold their final values until the next LOAD.
- Upstream inputs x_pos/run/rise/dir are used only in LOAD; later changes do not affect a shot in flight.
- Reset mid-flight: immediate return to IDLE with all reset values; no hit or miss pulse.

Test Plan:
- Hit, diagonal right: x_pos=10, dir=1, run=1, rise=1, target=(13,3); fire, then ticks.
  - Required: shot passes (11,1), (12,2), (13,3).
  - hit pulses once after the 3rd tick, miss stays 0, shots_fired=1, aim_lock=1 from the cycle after fire.
- Left wall miss: x_pos=3, dir=0, run=2, rise=1, target=(0,9).
  - Required: tick 1 gives (1,1).
  - Tick 2 pulses miss; shot stays at (1,1) and state goes to COOL.
- Top miss: run=0, rise=1, x_pos=5, Y_MAX=23, no target on the path.
  - Required: tick 23 gives (5,23).
  - Tick 24 pulses miss.
- Ignored fires: hold fire=1 through FLY and COOL, with COOLDOWN=8.
  - Required: shots_fired increments only once.
  - IDLE is reached on the 8th tick after miss/hit; with fire still high, a new LOAD follows and shots_fired=2.
- Degenerate aim: run=0, rise=0.
  - Required: the cycle after LOAD pulses miss and enters COOL, with no FLY.
- Async reset mid-flight: assert reset=0 between ticks in FLY.
  - Required: all outputs go to 0 immediately, no hit or miss pulse.
  - After release, a fire is accepted normally.
